// File: rtl/spi_arbiter.sv
// Round-robin scheduler sharing one SPI frame engine between N_REQ requesters.
// Optional per-frame watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
   parameter int N_REQ       = 4,
   parameter int F_SIZE      = 8,
   parameter int F_NUM_MAX   = 4,
   parameter int GAP_CYC     = 4,
   parameter int TIMEOUT_CYC = 1024,
   localparam int FC_W       = $clog2(F_NUM_MAX + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_i,
   input  logic [N_REQ*FC_W-1:0]     nframes_i,
   input  logic [N_REQ*F_SIZE-1:0]   data_i,
   output logic [N_REQ-1:0]          data_rd_o,
   output logic [N_REQ-1:0]          grant_o,
   output logic [N_REQ-1:0]          done_o,
   output logic                      start_o,
   output logic [F_SIZE-1:0]         frame_data_o,
   input  logic                      frame_done_i,
   output logic                      cs_n_o,
   output logic                      err_o,
   output logic [2:0]                state_d
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int GC_W  = $clog2(GAP_CYC + 1);

   if (N_REQ < 2 || GAP_CYC < 1 || F_NUM_MAX < 1 || TIMEOUT_CYC < 1) begin : g_param_chk
      $error("spi_arbiter: illegal parameter value");
   end

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARB  = 3'd1,
      S_LOAD = 3'd2,
      S_WAIT = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [PTR_W-1:0]   r_last, w_win;
   logic               w_win_vld;
   logic [N_REQ-1:0]   w_win_oh;
   logic [N_REQ-1:0]   r_grant, r_data_rd;
   logic [FC_W-1:0]    r_nfr, r_fcnt, w_fcnt_inc, w_nfr_sel, w_nfr_clamp;
   logic [GC_W-1:0]    r_gcnt;
   logic               r_start, r_cs_n;
   logic [F_SIZE-1:0]  r_fdata, w_fdata;
   logic               w_gap_last, w_frame_last, w_tmo;

   // Rotating priority: offset 1 from last winner is highest, offset N_REQ (itself) lowest.
   always_comb begin
      w_win     = '0;
      w_win_vld = 1'b0;
      for (int i = N_REQ; i >= 1; i--) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (req_i[j] && ((int'(r_last) + i == j) || (int'(r_last) + i == j + N_REQ))) begin
               w_win     = PTR_W'(j);
               w_win_vld = 1'b1;
            end
         end
      end
   end

   assign w_win_oh = N_REQ'(1) << w_win;

   always_comb begin
      w_fdata   = '0;
      w_nfr_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_last == PTR_W'(i)) w_fdata   = data_i[i*F_SIZE +: F_SIZE];
         if (w_win  == PTR_W'(i)) w_nfr_sel = nframes_i[i*FC_W +: FC_W];
      end
   end

   always_comb begin
      w_nfr_clamp = w_nfr_sel;
      if (w_nfr_sel == '0)
         w_nfr_clamp = FC_W'(1);
      else if (w_nfr_sel > FC_W'(F_NUM_MAX))
         w_nfr_clamp = FC_W'(F_NUM_MAX);
   end

   assign w_fcnt_inc   = r_fcnt + 1'b1;
   assign w_frame_last = (w_fcnt_inc == r_nfr);
   assign w_gap_last   = (r_state == S_GAP) && (r_gcnt == GC_W'(GAP_CYC - 1));

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] r_wd;
   logic            r_err;

   assign w_tmo = (r_state == S_WAIT) && (r_wd == WD_W'(TIMEOUT_CYC - 1));
   assign err_o = r_err;

   // A frame completing on the timeout cycle wins over the watchdog.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd  <= '0;
         r_err <= 1'b0;
      end else begin
         r_err <= w_tmo && !frame_done_i;
         if (r_state == S_LOAD)
            r_wd <= '0;
         else if (r_state == S_WAIT)
            r_wd <= r_wd + 1'b1;
      end
   end
`else
   assign w_tmo = 1'b0;
   assign err_o = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (|req_i) w_state_nxt = S_ARB;
         S_ARB:  w_state_nxt = w_win_vld ? S_LOAD : S_IDLE;
         S_LOAD: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (frame_done_i)
               w_state_nxt = w_frame_last ? S_GAP : S_LOAD;
            else if (w_tmo)
               w_state_nxt = S_GAP;
         end
         S_GAP:  if (w_gap_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_last    <= PTR_W'(N_REQ - 1);
         r_grant   <= '0;
         r_data_rd <= '0;
         r_start   <= 1'b0;
         r_cs_n    <= 1'b1;
         r_fdata   <= '0;
         r_nfr     <= '0;
         r_fcnt    <= '0;
         r_gcnt    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_start   <= (r_state == S_LOAD);
         r_data_rd <= (r_state == S_LOAD) ? r_grant : '0;
         case (r_state)
            S_ARB: begin
               if (w_win_vld) begin
                  r_grant <= w_win_oh;
                  r_last  <= w_win;
                  r_nfr   <= w_nfr_clamp;
                  r_fcnt  <= '0;
               end
            end
            S_LOAD: begin
               r_fdata <= w_fdata;
               r_cs_n  <= 1'b0;
            end
            S_WAIT: begin
               if (frame_done_i)
                  r_fcnt <= w_fcnt_inc;
               if (w_state_nxt == S_GAP) begin
                  r_cs_n <= 1'b1;
                  r_gcnt <= '0;
               end
            end
            S_GAP: begin
               r_gcnt <= r_gcnt + 1'b1;
               if (w_gap_last)
                  r_grant <= '0;
            end
            default: ;
         endcase
      end
   end

   assign grant_o      = r_grant;
   assign data_rd_o    = r_data_rd;
   assign start_o      = r_start;
   assign frame_data_o = r_fdata;
   assign cs_n_o       = r_cs_n;
   assign done_o       = w_gap_last ? r_grant : '0;
   assign state_d      = r_state;

endmodule
